// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: fixed-latency Ibex LSU data memory with grant/response pipeline, SECDED integrity under `IBEX_MEM_RESP_INTG_EN
module ibex_data_mem_responder #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MemDepth = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr = 32'h0010_0000,
  parameter int RespLatency = 1
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  input  logic [6:0]           data_wdata_intg_i,
  input  logic                 stall_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic                 data_err_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic [6:0]           data_rdata_intg_o
);
  localparam int IW = $clog2(MemDepth);
  logic [DataWidth-1:0] mem [MemDepth];
  logic rst_q, acc, in_rng, intg_ok, wr_en, unused;
  logic [IW-1:0] idx;
  logic [DataWidth-1:0] rdata_d;
  logic [6:0] intg_d;
  logic [RespLatency-1:0] vld_q, err_q;
  logic [DataWidth-1:0] rd_q [RespLatency];
  logic [6:0] ig_q [RespLatency];
`ifdef IBEX_MEM_RESP_INTG_EN
  function automatic logic [6:0] enc(logic [31:0] d);
    return {^(d & 32'h98505586), ^(d & 32'h2DCC624C), ^(d & 32'hC2C1323B), ^(d & 32'h31234ED1),
            ^(d & 32'h413D89AA), ^(d & 32'hDEBA8050), ^(d & 32'h2606BD25)} ^ 7'h2A;
  endfunction
  assign intg_ok = enc(data_wdata_i) == data_wdata_intg_i;
  assign intg_d = acc ? enc(rdata_d) : '0;
`else
  assign intg_ok = 1'b1;
  assign intg_d = '0;
`endif
  assign data_gnt_o = data_req_i & ~stall_i & rst_q;
  assign acc = data_req_i & data_gnt_o;
  assign in_rng = data_addr_i[AddrWidth-1:IW+2] == BaseAddr[AddrWidth-1:IW+2];
  assign idx = data_addr_i[IW+1:2];
  assign wr_en = acc & data_we_i & in_rng & intg_ok;
  assign rdata_d = (acc & ~data_we_i & in_rng) ? mem[idx] : '0;
  assign unused = ^{data_addr_i[1:0], data_wdata_intg_i};
  assign data_rvalid_o = vld_q[RespLatency-1];
  assign data_err_o = err_q[RespLatency-1];
  assign data_rdata_o = rd_q[RespLatency-1];
  assign data_rdata_intg_o = ig_q[RespLatency-1];
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) rst_q <= 1'b0;
    else rst_q <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        rd_q[i] <= '0;
        ig_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= acc;
      err_q[0] <= acc & (~in_rng | (data_we_i & ~intg_ok));
      rd_q[0] <= rdata_d;
      ig_q[0] <= intg_d;
      for (int i = 1; i < RespLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        rd_q[i] <= rd_q[i-1];
        ig_q[i] <= ig_q[i-1];
      end
    end
endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// tb_ibex_data_mem_responder: directed self-checking bench for ibex_data_mem_responder at latency 1 and 4
module tb_ibex_data_mem_responder;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [31:0] LAST = 32'h0010_0FFC;
  localparam logic [31:0] OOR = 32'h0010_1000;
  localparam logic [31:0] BELOW = 32'h000F_FFFC;
`ifdef IBEX_MEM_RESP_INTG_EN
  localparam logic [6:0] INTG0 = 7'h2A;
`else
  localparam logic [6:0] INTG0 = 7'h00;
`endif
  logic clk = 1'b0, rst_ni = 1'b0, req = 1'b0, we = 1'b0, stall = 1'b0;
  logic [31:0] addr = BASE, wdata = '0;
  logic [3:0] be = 4'hF;
  logic [6:0] wintg = '0;
  logic gnt, rvalid, err, gnt4, rvalid4, err4;
  logic [31:0] rdata, rdata4;
  logic [6:0] rintg, rintg4;
  logic [31:0] vals [4];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ibex_data_mem_responder #(.RespLatency(1)) dut (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_wdata_intg_i(wintg), .stall_i(stall),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_err_o(err), .data_rdata_o(rdata),
    .data_rdata_intg_o(rintg)
  );
  ibex_data_mem_responder #(.RespLatency(4)) dut4 (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_wdata_intg_i(wintg), .stall_i(stall),
    .data_gnt_o(gnt4), .data_rvalid_o(rvalid4), .data_err_o(err4), .data_rdata_o(rdata4),
    .data_rdata_intg_o(rintg4)
  );
  function automatic logic [6:0] enc(logic [31:0] d);
    return {^(d & 32'h98505586), ^(d & 32'h2DCC624C), ^(d & 32'hC2C1323B), ^(d & 32'h31234ED1),
            ^(d & 32'h413D89AA), ^(d & 32'hDEBA8050), ^(d & 32'h2606BD25)} ^ 7'h2A;
  endfunction
  task automatic xfer(input logic we_v, input logic [31:0] a, input logic [3:0] be_v,
                      input logic [31:0] wd, input logic bad, output logic g, output logic v0,
                      output logic v, output logic [31:0] rd, output logic e, output logic [6:0] ig);
    @(negedge clk);
    req = 1'b1; we = we_v; addr = a; be = be_v; wdata = wd; wintg = bad ? 7'h00 : enc(wd);
    #1 g = gnt; v0 = rvalid;
    @(posedge clk);
    @(negedge clk);
    v = rvalid; rd = rdata; e = err; ig = rintg;
    req = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    req = 1'b1;
    #1;
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", gnt); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if (rintg !== 7'h0) begin errors++; $display("FAIL rst_intg got %h exp 0", rintg); end
    checks++; if (rvalid4 !== 1'b0) begin errors++; $display("FAIL rst_rvalid4 got %b exp 0", rvalid4); end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rel_gnt_before_edge got %b exp 0", gnt); end
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    #1;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rel_gnt_after_edge got %b exp 1", gnt); end
    req = 1'b0;
  endtask
  task automatic test_write_read();
    logic g, v0, v, e;
    logic [31:0] rd;
    logic [6:0] ig;
    xfer(1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", g); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL wr_rvalid_early got %b exp 0", v0); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL wr_rvalid got %b exp 1", v); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
    checks++; if (ig !== INTG0) begin errors++; $display("FAIL wr_intg got %h exp %h", ig, INTG0); end
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid_one_cycle got %b exp 0", rvalid); end
    xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b exp 1", v); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", e); end
  endtask
  task automatic test_partial();
    logic g, v0, v, e;
    logic [31:0] rd;
    logic [6:0] ig;
    xfer(1'b1, BASE + 32'h10, 4'b0101, 32'h11223344, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL pw_err got %b exp 0", e); end
    xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL pw_rdata got %h exp de22be44", rd); end
  endtask
  task automatic test_range();
    logic g, v0, v, e;
    logic [31:0] rd;
    logic [6:0] ig;
    xfer(1'b0, OOR, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL oor_rvalid got %b exp 1", v); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", rd); end
    checks++; if (ig !== INTG0) begin errors++; $display("FAIL oor_intg got %h exp %h", ig, INTG0); end
    xfer(1'b1, LAST, 4'hF, 32'h5A5A5A5A, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_wr_err got %b exp 0", e); end
    xfer(1'b1, BELOW, 4'hF, 32'hFFFFFFFF, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_wr_err got %b exp 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_wr_rdata got %h exp 0", rd); end
    xfer(1'b0, LAST, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL last_rdata got %h exp 5a5a5a5a", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_err got %b exp 0", e); end
  endtask
  task automatic test_back_to_back();
    logic g, v0, v, e;
    logic [31:0] rd;
    logic [6:0] ig;
    for (int i = 0; i < 4; i++)
      xfer(1'b1, BASE + 32'h20 + 32'(4 * i), 4'hF, vals[i], 1'b0, g, v0, v, rd, e, ig);
    stall = 1'b1; req = 1'b1; we = 1'b0; addr = BASE + 32'h20;
    repeat (3) begin
      #1;
      checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt got %b exp 0", gnt); end
      @(negedge clk);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = BASE + 32'h20 + 32'(4 * i);
      #1;
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b exp 1", i, gnt); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d got %b exp 1", i, rvalid); end
      checks++; if (rdata !== vals[i]) begin errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, rdata, vals[i]); end
    end
    req = 1'b0;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", rvalid); end
  endtask
  task automatic test_reset_flush();
    repeat (6) @(negedge clk);
    req = 1'b1; we = 1'b0; addr = BASE + 32'h20;
    @(posedge clk);
    @(negedge clk);
    addr = BASE + 32'h24;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++; if (rvalid4 !== 1'b0) begin errors++; $display("FAIL l4_early got %b exp 0", rvalid4); end
    @(negedge clk);
    checks++; if (rvalid4 !== 1'b1) begin errors++; $display("FAIL l4_rvalid got %b exp 1", rvalid4); end
    checks++; if (rdata4 !== vals[0]) begin errors++; $display("FAIL l4_rdata got %h exp %h", rdata4, vals[0]); end
    rst_ni = 1'b0;
    #1;
    checks++; if (rvalid4 !== 1'b0) begin errors++; $display("FAIL flush_rvalid got %b exp 0", rvalid4); end
    checks++; if (rdata4 !== 32'h0) begin errors++; $display("FAIL flush_rdata got %h exp 0", rdata4); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++; if (rvalid4 !== 1'b0) begin errors++; $display("FAIL flush_ghost got %b exp 0", rvalid4); end
    end
    req = 1'b1; addr = BASE + 32'h24;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rvalid4 !== 1'b1) begin errors++; $display("FAIL reread_rvalid got %b exp 1", rvalid4); end
    checks++; if (rdata4 !== vals[1]) begin errors++; $display("FAIL reread_rdata got %h exp %h", rdata4, vals[1]); end
  endtask
`ifdef IBEX_MEM_RESP_INTG_EN
  task automatic test_intg();
    logic g, v0, v, e;
    logic [31:0] rd;
    logic [6:0] ig;
    xfer(1'b1, BASE + 32'h40, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL intg_wr_err got %b exp 0", e); end
    xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (ig !== 7'h2A) begin errors++; $display("FAIL intg_rd got %h exp 2a", ig); end
    xfer(1'b1, BASE + 32'h40, 4'hF, 32'hFFFFFFFF, 1'b1, g, v0, v, rd, e, ig);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL intg_bad_err got %b exp 1", e); end
    xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, 1'b0, g, v0, v, rd, e, ig);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL intg_unchanged got %h exp 0", rd); end
  endtask
`endif
  initial begin
    vals[0] = 32'h0BAD0001; vals[1] = 32'h1234ABCD; vals[2] = 32'hC0FFEE02; vals[3] = 32'h80000003;
    test_reset();
    test_write_read();
    test_partial();
    test_range();
    test_back_to_back();
    test_reset_flush();
`ifdef IBEX_MEM_RESP_INTG_EN
    test_intg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_data_mem_responder.md
# ibex_data_mem_responder

Synthesizable responder for the Ibex core data-memory port: it accepts LSU requests, grants them, and returns read data or write completions with a fixed latency, backed by an internal word-addressed memory. It is the device end of the data-side signals the core-facing monitor interface observes. It is used as the data memory in the core-level testbench and in FPGA bring-up builds.

## Interface
- `AddrWidth`, default 32: request address width.
- `DataWidth`, default 32: data width. Only 32 is supported; `data_be_i` is 4 bits.
- `MemDepth`, default 1024: number of memory words. Must be a power of two.
- `BaseAddr`, default 32'h0010_0000: byte address of word 0. Must be aligned to `MemDepth*4`.
- `RespLatency`, default 1: cycles from grant to `rvalid`. Legal range is 1..8.
- `clk` input, 1 bit: clock, rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `data_req_i` input, 1 bit: request valid.
- `data_addr_i` input, `AddrWidth` bits: byte address. Bits [1:0] are ignored.
- `data_we_i` input, 1 bit: 1 = write, 0 = read.
- `data_be_i` input, 4 bits: write byte enables.
- `data_wdata_i` input, `DataWidth` bits: write data.
- `data_wdata_intg_i` input, 7 bits: write-data integrity.
- `stall_i` input, 1 bit: when 1, forces `data_gnt_o` low.
- `data_gnt_o` output, 1 bit: request granted.
- `data_rvalid_o` output, 1 bit: response valid.
- `data_err_o` output, 1 bit: response error. Qualified by `rvalid`.
- `data_rdata_o` output, `DataWidth` bits: read data.
- `data_rdata_intg_o` output, 7 bits: read-data integrity.

## Operation
- Grant rule: `data_gnt_o = data_req_i & ~stall_i & rst_q`. This is combinational. `rst_q` is a flop cleared by reset and set on the first clock edge after reset is released.
- A request is accepted on any rising edge where req and gnt are both 1. No other condition accepts a request.
- In-range check: `data_addr_i` is in [`BaseAddr`, `BaseAddr + MemDepth*4`). Word index = `addr[log2(MemDepth)+1:2]`.
- Accepted write, in range, no integrity error:
  - Each byte with `be[i]=1` is written on the accept edge.
  - Response has `rdata=0`, `err=0`.
- Accepted read, in range: `rdata` is the word as sampled on the accept edge, `err=0`.
- Out-of-range access:
  - Response has `err=1`, `rdata=0`.
  - A write does not modify memory.
- Response pipeline: a shift register `RespLatency` deep carrying {valid, err, rdata, intg}. It is in-order and never backpressured. Up to `RespLatency` responses can be in flight.
- Memory contents are not reset. They are X until written.

## Timing
- A request accepted at edge N produces `data_rvalid_o=1` for exactly one cycle, starting after edge N+`RespLatency`-1. With `RespLatency`=1, rvalid is high in the cycle after the grant cycle.
- Back-to-back accepts on every edge produce rvalid high on every cycle, in the same order as the accepts.
- Read-after-write at consecutive accepts returns the newly written data. The write commits on its accept edge.
- A request held while `stall_i=1` sees gnt=0. It is granted in the first cycle with `stall_i=0`, with no extra latency.
- Reset values: `data_rvalid_o=0`, `data_err_o=0`, `data_rdata_o=0`, `data_rdata_intg_o=0`, `data_gnt_o=0`.
- Reset asserted mid-operation:
  - The pipeline clears immediately (asynchronously). In-flight responses are dropped and never emitted.
  - Memory keeps its contents.
  - gnt stays 0 until the first edge after reset is released.
- `rdata_o`, `err_o` and `intg_o` are 0 whenever `rvalid_o=0`.

## Configuration
- Macro: `IBEX_MEM_RESP_INTG_EN`.
- Defined:
  - `data_rdata_intg_o` = inverted Hsiao SECDED(39,32) check bits of `rdata`, as `prim_secded_inv_39_32_enc` computes them. For rdata=0 this is 7'h2A.
  - On writes, `data_wdata_intg_i` is compared with the same encoding of `data_wdata_i`. On mismatch the response has `err=1` and memory is not written.
- Undefined:
  - `data_rdata_intg_o` = 0 always.
  - `data_wdata_intg_i` is ignored.

## Test plan
1. Write 32'hDEADBEEF, `be`=4'hF, to `BaseAddr`+0x10, then read the same address.
   - Read returns rdata 32'hDEADBEEF, err 0.
   - Each rvalid arrives exactly `RespLatency` cycles after its grant.
2. Partial write: write 32'h11223344 with `be`=4'b0101 over 32'hDEADBEEF, then read. Read returns 32'hDE22BE44.
3. Range errors:
   - Read `BaseAddr`+`MemDepth`*4 returns err 1, rdata 0.
   - Write 32'hFFFFFFFF to `BaseAddr`-4, then read `BaseAddr`+`MemDepth`*4-4. The last word is unchanged.
4. Hold req with `stall_i`=1 for 3 cycles, then 0, then issue 4 back-to-back reads.
   - gnt is 0 for 3 cycles, then 1.
   - 4 consecutive rvalids arrive in request order.
5. Issue 2 reads with `RespLatency`=4, then pull `rst_ni` low 1 cycle after the second grant.
   - rvalid drops to 0 immediately.
   - No responses appear after reset is released.
   - Memory data is intact on re-read.
6. With `IBEX_MEM_RESP_INTG_EN` defined:
   - Write 0 with correct intg 7'h2A, then read: returns intg 7'h2A.
   - Write with intg 7'h00: returns err 1 and memory is unchanged.
